// File: rtl/rvsteel_bus_pkg.sv
// Shared definitions for the rvsteel bus slice: FSM state and transaction type encodings.
package rvsteel_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bus_state_e;

    typedef enum logic {
        TYPE_READ  = 1'b0,
        TYPE_WRITE = 1'b1
    } bus_type_e;

    // Width of the wait counter; one bit minimum so a disabled timeout still elaborates.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rvsteel_bus_timeout_counter.sv
// Wait-cycle counter for the bus slice; tc_o flags the last permitted WAIT cycle.
module rvsteel_bus_timeout_counter
    import rvsteel_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic count_en_i,
    input  logic clear_i,
    output logic tc_o
);

    localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign tc_o = 1'b0;
        end else begin : g_on
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count_q;
            logic [CW-1:0] count_d;

            always_comb begin
                count_d = count_q;
                if (clear_i) begin
                    count_d = '0;
                end else if (count_en_i) begin
                    count_d = count_q + 1'b1;
                end
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_d;
                end
            end

            assign tc_o = (count_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/rvsteel_bus_slice.sv
// Registered bus slice between the rvsteel core IO port and one subordinate,
// tracking a single outstanding transaction with a bounded wait.
module rvsteel_bus_slice
    import rvsteel_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES    = 1024,
    parameter logic [31:0] TIMEOUT_READ_DATA = 32'hDEADBEEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] m_rw_address,
    output logic [31:0] m_read_data,
    input  logic        m_read_request,
    output logic        m_read_response,
    input  logic [31:0] m_write_data,
    input  logic [3:0]  m_write_strobe,
    input  logic        m_write_request,
    output logic        m_write_response,
    output logic [31:0] s_rw_address,
    input  logic [31:0] s_read_data,
    output logic        s_read_request,
    input  logic        s_read_response,
    output logic [31:0] s_write_data,
    output logic [3:0]  s_write_strobe,
    output logic        s_write_request,
    input  logic        s_write_response,
    output logic        timeout_flag
);

    bus_state_e  state_q, state_d;
    bus_type_e   type_q, type_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  strb_q, strb_d;
    logic        rreq_q, rreq_d;
    logic        wreq_q, wreq_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tflag_q, tflag_d;

    logic        resp_hit;
    logic        in_wait;
    logic        tc;

    assign in_wait  = (state_q == WAIT);
    assign resp_hit = (type_q == TYPE_READ) ? s_read_response : s_write_response;

    rvsteel_bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .count_en_i(in_wait && !resp_hit),
        .clear_i   (state_d != WAIT),
        .tc_o      (tc)
    );

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        strb_d  = strb_q;
        rreq_d  = rreq_q;
        wreq_d  = wreq_q;
        rdata_d = rdata_q;
        tflag_d = tflag_q;
        case (state_q)
            IDLE: begin
                if (m_write_request) begin
                    type_d  = TYPE_WRITE;
                    addr_d  = m_rw_address;
                    wdata_d = m_write_data;
                    strb_d  = m_write_strobe;
                    wreq_d  = 1'b1;
                    state_d = WAIT;
                end else if (m_read_request) begin
                    type_d  = TYPE_READ;
                    addr_d  = m_rw_address;
                    strb_d  = 4'h0;
                    rreq_d  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A real response beats a timeout landing in the same cycle.
                if (resp_hit) begin
                    if (type_q == TYPE_READ) rdata_d = s_read_data;
                    rreq_d  = 1'b0;
                    wreq_d  = 1'b0;
                    state_d = RESP;
                end else if (tc) begin
                    if (type_q == TYPE_READ) rdata_d = TIMEOUT_READ_DATA;
                    tflag_d = 1'b1;
                    rreq_d  = 1'b0;
                    wreq_d  = 1'b0;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rreq_d  = 1'b0;
                wreq_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            type_q  <= TYPE_READ;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rreq_q  <= 1'b0;
            wreq_q  <= 1'b0;
            rdata_q <= '0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rreq_q  <= rreq_d;
            wreq_q  <= wreq_d;
            rdata_q <= rdata_d;
            tflag_q <= tflag_d;
        end
    end

    assign s_rw_address     = addr_q;
    assign s_write_data     = wdata_q;
    assign s_write_strobe   = strb_q;
    assign s_read_request   = rreq_q;
    assign s_write_request  = wreq_q;
    assign m_read_data      = rdata_q;
    assign m_read_response  = (state_q == RESP) && (type_q == TYPE_READ);
    assign m_write_response = (state_q == RESP) && (type_q == TYPE_WRITE);
    assign timeout_flag     = tflag_q;

endmodule

// File: doc/rvsteel_bus_slice.md
Name: rvsteel_bus_slice

Overview:
- Registered bus slice between the rvsteel_core IO interface (manager side, m_*) and one memory-mapped subordinate such as rvsteel_ram (subordinate side, s_*).
- Breaks the combinational path between core and subordinate.
- Tracks the single outstanding transaction.
- Bounds the wait for a response with a timeout, so an unresponsive subordinate cannot hang the core.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles in WAIT before forced completion. 0 disables the timeout.
- TIMEOUT_READ_DATA, 32'hDEADBEEF: value returned on m_read_data for a timed-out read.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- m_rw_address  in  32  manager address.
- m_read_data  out  32  read data to manager.
- m_read_request  in  1  manager read request.
- m_read_response  out  1  read completion pulse.
- m_write_data  in  32  manager write data.
- m_write_strobe  in  4  byte enables.
- m_write_request  in  1  manager write request.
- m_write_response  out  1  write completion pulse.
- s_rw_address  out  32  registered address.
- s_read_data  in  32  subordinate read data.
- s_read_request  out  1  registered read request.
- s_read_response  in  1  subordinate read completion.
- s_write_data  out  32  registered write data.
- s_write_strobe  out  4  registered strobe.
- s_write_request  out  1  registered write request.
- s_write_response  in  1  subordinate write completion.
- timeout_flag  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE.
  - All s_* outputs are 0.
  - m_read_data=0, m_read_response=0, m_write_response=0.
  - timeout_flag=0, timeout counter=0.
- Protocol:
  - Manager holds request and payload stable until the cycle in which it samples the response.
  - In the following cycle it either deasserts the request or presents a new one.
  - Responses are single-cycle pulses.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If m_write_request=1, register address, data, strobe and type=write. The write takes priority if both requests are high; m_read_request is ignored.
  - Otherwise, if m_read_request=1, register address and type=read. s_write_data is unchanged and s_write_strobe is forced to 0.
  - Next state is WAIT. The matching s_*_request is asserted from the register in the next cycle.
  - No request: stay in IDLE.
- WAIT:
  - s_*_request and payload are held constant.
  - If the response matching the registered type is 1: latch s_read_data (reads only), deassert s_*_request, go to RESP.
  - A response of the wrong type is ignored.
  - Otherwise the counter increments. When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without a response:
    - latch TIMEOUT_READ_DATA (reads only);
    - set timeout_flag;
    - deassert s_*_request;
    - go to RESP.
  - A response arriving in the same cycle as the timeout wins: real data is used and the flag is not set.
  - The counter is cleared on leaving WAIT.
- RESP:
  - Assert m_read_response or m_write_response for exactly one cycle, then go to IDLE.
  - m_read_data holds its value until the next read completes.
- s_*_response arriving in IDLE or RESP is ignored.
- Latency: manager request in cycle 0, s_request in cycle 1, subordinate response in cycle k≥1, m_response in cycle k+1. With rvsteel_ram (k=2) this gives 3 cycles.
- Back-to-back: a new request is accepted in the IDLE cycle directly after RESP.
  - Throughput with rvsteel_ram is one transaction per 4 cycles.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.
- Reset during WAIT aborts the transaction. s_*_request drops immediately (asynchronous) and no m_response is generated.

Decomposition:
- Shared package rvsteel_bus_pkg holds:
  - state encoding constants IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - transaction type constants TYPE_READ, TYPE_WRITE.
- One sub-module, rvsteel_bus_timeout_counter, contains the counter plus a terminal-count output and is disabled when TIMEOUT_CYCLES=0.
- Everything else lives in one module.

Test Plan:
- Write then read with rvsteel_ram on s_*:
  - write 0x00000010 = 0xA5A5_1234, strobe 4'hF → m_write_response in cycle 3;
  - read 0x00000010 → m_read_data=0xA5A51234 with m_read_response in cycle 3.
- Byte strobe: write 0x11223344 to 0x20, then write 0x000000FF with strobe 4'b0001 → read returns 0x112233FF.
- Timeout: subordinate never responds, TIMEOUT_CYCLES=8, read 0x40 →
  - s_read_request high for exactly 8 cycles;
  - m_read_response with 0xDEADBEEF;
  - timeout_flag=1 and stays 1.
- Response and timeout coincide: subordinate returns 0x5555AAAA on the terminal cycle → that data is delivered and timeout_flag stays 0.
- Both m_read_request and m_write_request high in IDLE → only s_write_request is issued and only m_write_response is pulsed.
- Reset during WAIT: reset=0 in cycle 1 → all s_* requests are 0 in the same cycle and no m_response is produced. After release, a new read completes normally.
